mem_byte_initiator: RTL and testbench
=====================================

Name: mem_byte_initiator

Overview:
- MEM-stage initiator that drives the byte-wide data-memory port on behalf of the pipeline.
- Takes one 32-bit word load/store from the EXE/MEM register and splits it into four sequential byte transactions over a req/ack bus.
- Rebuilds the read word little-endian and freezes the pipeline until the access completes.
- Translates ARM word addresses into memory byte offsets by subtracting BASE_ADDR after word alignment.

Parameters:
- BASE_ADDR, 32'd1024, data-segment base subtracted from the word-aligned address.
- MEM_BYTES, 256, byte capacity of the responder; used only by the optional range check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- mem_r_en  in  1  load request from the pipeline.
- mem_w_en  in  1  store request from the pipeline.
- address  in  32  byte address; bits [1:0] ignored.
- dataToWrite  in  32  store data.
- result  out  32  assembled load word.
- freeze  out  1  pipeline stall.
- err  out  1  access error pulse.
- bus_req  out  1  byte transaction request.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  32  byte offset into memory.
- bus_wdata  out  8  write byte.
- bus_rdata  in  8  read byte.
- bus_ack  in  1  responder completes current byte.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; byte index = 0; bus_req = 0, bus_we = 0; bus_addr, bus_wdata, result = 0; err = 0; read register cleared.
  - Reset mid-transfer drops bus_req immediately and discards partial data.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If mem_w_en or mem_r_en, latch op, word base = {address[31:2],2'b00} - BASE_ADDR, and dataToWrite; next state BUSY with index 0.
  - Both enables high: the write is performed and result stays 0.
- BUSY:
  - bus_req = 1 (registered).
  - bus_addr = base + index.
  - bus_wdata = data[8*index+7 : 8*index].
  - bus_we = latched op.
  - Outputs stay stable until bus_ack is sampled high at a rising edge.
  - On each ack edge: for a read, capture bus_rdata into byte lane [index]; then increment index. After the ack on index 3, go to DONE and drop bus_req.
  - Wait states are unbounded; bus_ack sampled while bus_req = 0 is ignored.
- DONE: lasts one cycle, then IDLE unconditionally.
- freeze = (IDLE and (mem_r_en or mem_w_en)) or BUSY. It is combinational, so the stall begins in the request cycle. freeze = 0 in DONE, so the MEM/WB register captures result at the edge leaving DONE.
- result = assembled word in DONE for reads; 0 in every other state and for writes. This matches the codebase's 0-when-not-reading convention.
- Latency:
  - Zero-wait responder (ack high whenever req high): request cycle + 4 BUSY cycles + 1 DONE cycle.
  - Result is visible 5 edges after the request is presented.
  - Each responder wait cycle adds 1.
- Arithmetic: 32-bit modulo 2^32. The subtraction wraps for addresses below BASE_ADDR; no error unless the range check is enabled.
- Back-to-back requests: a request still present in the cycle after DONE starts a new access. Correctness relies on the pipeline having advanced.

Optional Feature:
- MEM_RANGE_CHECK_EN defined:
  - In IDLE, if base >= MEM_BYTES (unsigned, which includes wrapped values), no bus transaction is issued.
  - Next state is DONE directly; err = 1 for that DONE cycle only; result = 0; a write is dropped.
  - freeze is high for the request cycle only.
- Undefined: err is tied 0 and every offset is issued as computed.

Decomposition:
- Shared package (mem_pkg):
  - State enum {IDLE, BUSY, DONE}.
  - BYTES_PER_WORD = 4.
  - Default BASE_ADDR and MEM_BYTES constants, shared with the data-memory responder.
- No sub-module: the byte-lane select/insert is a few lines inside the block.

Test Plan:
- Store, zero-wait responder: address=0x404, dataToWrite=0xDEADBEEF.
  - Expect bus writes at offsets 4,5,6,7 with bytes EF,BE,AD,DE on consecutive cycles.
  - freeze high for 5 cycles; result = 0.
- Load, one wait cycle per byte: address=0x406, responder returns 11,22,33,44.
  - Expect bus_addr 4..7; result = 0x44332211 in DONE only.
  - freeze high for 9 cycles.
- Simultaneous mem_r_en=mem_w_en=1: address=0x400, data=0x01020304.
  - Expect write-only bytes 04,03,02,01; result stays 0.
- Reset asserted after the second ack of a load.
  - Expect bus_req=0 and freeze=0 immediately, state IDLE, result 0.
  - A following load of 0x400 returns fresh data.
- Address 0x3FC without MEM_RANGE_CHECK_EN: bus_addr 0xFFFFFFFC..0xFFFFFFFF issued.
- Address 0x3FC with MEM_RANGE_CHECK_EN: no bus_req; err pulses 1 cycle; result 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide data-memory port: access FSM states and
// the default memory map used by both the initiator and the data-memory responder.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int          BYTES_PER_WORD = 4;
   localparam logic [31:0] DEF_BASE_ADDR  = 32'd1024;
   localparam int unsigned DEF_MEM_BYTES  = 256;

endpackage

// File: rtl/mem_byte_initiator.sv
// MEM-stage initiator: splits one word load/store into four byte transactions on a
// req/ack bus and stalls the pipeline meanwhile. Define MEM_RANGE_CHECK_EN to reject
// offsets beyond the responder capacity with an err pulse instead of a bus access.
module mem_byte_initiator
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
`ifdef MEM_RANGE_CHECK_EN
   ,
   parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] dataToWrite,
   output logic [31:0] result,
   output logic        freeze,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ack
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   state_t      state_q, state_d;
   logic [1:0]  idx_q;
   logic        we_q;
   logic [31:0] base_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;

   logic        req;
   logic [31:0] base_in;
   logic        range_bad;
   logic        unused_addr_bits;

   assign req              = mem_r_en | mem_w_en;
   assign base_in          = {address[31:2], 2'b00} - BASE_ADDR;
   assign unused_addr_bits = ^address[1:0];

`ifdef MEM_RANGE_CHECK_EN
   logic err_q;
   // Unsigned compare also catches offsets that wrapped below BASE_ADDR.
   assign range_bad = (base_in >= 32'(MEM_BYTES));
`else
   assign range_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req) state_d = range_bad ? DONE : BUSY;
         BUSY:    if (bus_ack && (idx_q == LAST_IDX)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values; the read word is reset too, so no stale bytes survive a reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q   <= '0;
         we_q    <= 1'b0;
         base_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MEM_RANGE_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         if (state_q == IDLE && req) begin
            idx_q   <= '0;
            we_q    <= mem_w_en;
            base_q  <= base_in;
            wdata_q <= dataToWrite;
`ifdef MEM_RANGE_CHECK_EN
            err_q   <= range_bad;
`endif
         end else if (state_q == BUSY && bus_ack) begin
            if (!we_q) rdata_q[8*idx_q +: 8] <= bus_rdata;
            idx_q <= idx_q + 2'd1;
         end
      end
   end

   // Bus outputs decode only registered state, so they hold steady through wait states.
   always_comb begin
      // NOTE: every output is defaulted first so no branch can infer a latch.
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      result    = '0;
      err       = 1'b0;
      freeze    = rst & (((state_q == IDLE) & req) | (state_q == BUSY));
      case (state_q)
         BUSY: begin
            bus_req   = 1'b1;
            bus_we    = we_q;
            bus_addr  = base_q + 32'(idx_q);
            bus_wdata = wdata_q[8*idx_q +: 8];
         end
         DONE: begin
`ifdef MEM_RANGE_CHECK_EN
            err = err_q;
            if (!we_q && !err_q) result = rdata_q;
`else
            if (!we_q) result = rdata_q;
`endif
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Scoreboard bench for mem_byte_initiator: a driver pushes expected bus bytes and
// completion words from a word-level memory model; a monitor pops and compares.
module tb_mem_byte_initiator;

   localparam logic [31:0] BASE     = 32'd1024;
   localparam logic [31:0] MEM_SIZE = 32'd256;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_r_en, mem_w_en;
   logic [31:0] address, dataToWrite;
   logic [31:0] result;
   logic        freeze, err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [7:0]  bus_wdata, bus_rdata;
   logic        bus_ack;

   always #5 clk = ~clk;

   mem_byte_initiator dut (
      .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .address(address), .dataToWrite(dataToWrite), .result(result),
      .freeze(freeze), .err(err), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack)
   );

   typedef struct {logic [31:0] addr; logic we; logic [7:0] wdata;} txn_t;
   typedef struct {logic [31:0] result; logic err;} done_t;

   txn_t        exp_txn[$];
   done_t       exp_done[$];
   logic [7:0]  ref_mem  [logic [31:0]];
   logic [7:0]  resp_mem [logic [31:0]];
   int          errors = 0;
   int          checks = 0;
   int          cur_wait = 0;
   int          wait_left = 0;
   int          ack_cnt = 0;

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Responder: programmable wait states per byte, spurious acks while idle.
   initial begin
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
      forever begin
         @(negedge clk);
         bus_ack = 1'b0;
         if (rst && bus_req) begin
            if (wait_left > 0) wait_left--;
            else begin
               bus_ack = 1'b1;
               if (bus_we) resp_mem[bus_addr] = bus_wdata;
               else bus_rdata = resp_mem.exists(bus_addr) ? resp_mem[bus_addr] : init_byte(bus_addr);
               ack_cnt++;
               wait_left = cur_wait;
            end
         end else begin
            wait_left = cur_wait;
            bus_ack   = ($urandom_range(0, 3) == 0);
         end
      end
   end

   // Monitor: compares accepted bus bytes and the completion cycle against the queues.
   initial begin
      logic  prev_freeze;
      txn_t  t;
      done_t d;
      prev_freeze = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) prev_freeze = 1'b0;
         else begin
            if (bus_req && bus_ack) begin
               if (exp_txn.size() == 0) check("unexpected_bus_txn", bus_addr, 32'hxxxx_xxxx);
               else begin
                  t = exp_txn.pop_front();
                  check("bus_addr", bus_addr, t.addr);
                  check("bus_we", 32'(bus_we), 32'(t.we));
                  if (t.we) check("bus_wdata", 32'(bus_wdata), 32'(t.wdata));
               end
            end
            if (prev_freeze && !freeze) begin
               if (exp_done.size() == 0) check("unexpected_completion", result, 32'hxxxx_xxxx);
               else begin
                  d = exp_done.pop_front();
                  check("result", result, d.result);
                  check("err", 32'(err), 32'(d.err));
               end
            end else begin
               check("quiet_result_err", 32'((|result) | err), 32'd0);
            end
            prev_freeze = freeze;
         end
      end
   end

   // One pipeline access: model the expectation, present the request, count stall cycles.
   task automatic access(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] data, input int waits);
      logic [31:0] base;
      logic [31:0] rd;
      logic        bad;
      int          exp_frz;
      int          frz;
      bit          done;
      txn_t        t;
      done_t       d;
      base = {addr[31:2], 2'b00} - BASE;
      rd   = '0;
      bad  = 1'b0;
`ifdef MEM_RANGE_CHECK_EN
      bad  = (base >= MEM_SIZE);
`endif
      if (bad) exp_frz = 1;
      else begin
         exp_frz = 1 + 4 * (1 + waits);
         for (int i = 0; i < 4; i++) begin
            t.addr  = base + 32'(i);
            t.we    = w;
            t.wdata = data[8*i +: 8];
            exp_txn.push_back(t);
            if (w) ref_mem[t.addr] = data[8*i +: 8];
            else rd[8*i +: 8] = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_byte(t.addr);
         end
      end
      d.result = (!w && !bad) ? rd : 32'd0;
      d.err    = bad;
      exp_done.push_back(d);
      cur_wait = waits;
      @(negedge clk);
      mem_r_en    = r;
      mem_w_en    = w;
      address     = addr;
      dataToWrite = data;
      frz  = 0;
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         #1;
         if (!freeze) begin
            done = 1'b1;
            break;
         end
         frz++;
         @(negedge clk);
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL access_timeout: freeze still %b after 200 cycles, addr %h", freeze, addr);
         finish_run();
      end
      check("freeze_cycles", 32'(frz), 32'(exp_frz));
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
   endtask

   initial begin
      int op;
      int ack_start;
      logic [31:0] a;
      rst = 1'b0;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      address = '0;
      dataToWrite = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_bus_we", 32'(bus_we), 32'd0);
      check("rst_bus_addr", bus_addr, 32'd0);
      check("rst_bus_wdata", 32'(bus_wdata), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_freeze", 32'(freeze), 32'd0);
      #2 rst = 1'b1;

      access(1'b0, 1'b1, 32'h0000_0404, 32'hDEAD_BEEF, 0);
      access(1'b0, 1'b1, 32'h0000_0404, 32'h4433_2211, 0);
      access(1'b1, 1'b0, 32'h0000_0406, 32'h0, 1);
      access(1'b1, 1'b1, 32'h0000_0400, 32'h0102_0304, 0);
      access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 2);

      // Reset after the second byte of a load is accepted.
      access(1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 0);
      for (int i = 0; i < 4; i++) begin
         exp_txn.push_back('{addr: 32'(i), we: 1'b0, wdata: 8'h00});
      end
      cur_wait  = 0;
      ack_start = ack_cnt;
      @(negedge clk);
      mem_r_en = 1'b1;
      address  = 32'h0000_0400;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         if (ack_cnt >= ack_start + 2) break;
      end
      #3 rst = 1'b0;
      #1;
      check("midreset_bus_req", 32'(bus_req), 32'd0);
      check("midreset_freeze", 32'(freeze), 32'd0);
      check("midreset_result", result, 32'd0);
      check("midreset_bus_addr", bus_addr, 32'd0);
      exp_txn.delete();
      exp_done.delete();
      @(negedge clk);
      #2;
      mem_r_en = 1'b0;
      rst = 1'b1;
      access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 0);

      access(1'b0, 1'b1, 32'h0000_03FC, 32'h1122_3344, 0);
      access(1'b1, 1'b0, 32'h0000_03FC, 32'h0, 1);

      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 32'($urandom_range(32'h300, 32'h5FF));
         else a = 32'h400 + 32'($urandom_range(0, 255));
         access((op == 0) || (op >= 2), (op == 1) || (op == 2), a, $urandom(),
                int'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
      check("done_queue_drained", 32'(exp_done.size()), 32'd0);
      finish_run();
   end

   initial begin
      #500000;
      errors++;
      checks++;
      $display("FAIL watchdog: simulation time limit reached");
      finish_run();
   end

endmodule
